terrain_scheduler: RTL and testbench



---
 rtl/terrain_pkg.sv | 26 ++
 rtl/terrain_pixel_mux.sv | 41 ++++
 rtl/terrain_scheduler.sv | 153 +++++++++++++++
 tb/tb_terrain_scheduler.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/terrain_pkg.sv
// Shared types and default geometry for the terrain scheduler and sprite renderers.
package terrain_pkg;

    localparam int COORD_W = 16;
    localparam int RGB_W   = 24;

    localparam int DEF_START_X = 880;
    localparam int DEF_START_Y = 360;
    localparam int DEF_MAX_X   = 1280;
    localparam int DEF_MAX_Y   = 720;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

endpackage

// File: rtl/terrain_pixel_mux.sv
// Priority pixel arbiter: the lowest-index active slot reporting a hit wins; registered output.
module terrain_pixel_mux
    import terrain_pkg::*;
#(
    parameter int NUM_SLOTS = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_SLOTS-1:0]       slot_hit,
    input  logic [NUM_SLOTS-1:0]       slot_active,
    input  logic [NUM_SLOTS*RGB_W-1:0] slot_rgb,
    output rgb_t                       pix_rgb,
    output logic                       pix_hit
);

    rgb_t win_rgb;
    logic win_hit;

    // Scan from the top down so the lowest-index candidate is the last to overwrite.
    always_comb begin
        win_rgb = '0;
        win_hit = 1'b0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (slot_hit[i] && slot_active[i]) begin
                win_hit = 1'b1;
                win_rgb = slot_rgb[i*RGB_W +: RGB_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_rgb <= '0;
            pix_hit <= 1'b0;
        end else begin
            pix_rgb <= win_rgb;
            pix_hit <= win_hit;
        end
    end

endmodule

// File: rtl/terrain_scheduler.sv
// Frame-rate terrain sequencer: spawns segments into a slot pool, moves them once per frame,
// retires off-screen segments and arbitrates the per-slot pixels for the compositor.
module terrain_scheduler
    import terrain_pkg::*;
#(
    parameter int NUM_SLOTS      = 4,
    parameter int SPAWN_INTERVAL = 32,
    parameter int START_X        = DEF_START_X,
    parameter int START_Y        = DEF_START_Y,
    parameter int MAX_X          = DEF_MAX_X,
    parameter int MAX_Y          = DEF_MAX_Y,
    parameter int STEP           = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_v_sync,
    input  logic                         i_active,
    input  logic                         i_state_check,
    input  logic [NUM_SLOTS-1:0]         i_slot_hit,
    input  logic [NUM_SLOTS*RGB_W-1:0]   i_slot_rgb,
    output logic [NUM_SLOTS-1:0]         o_slot_active,
    output logic [NUM_SLOTS*COORD_W-1:0] o_slot_x,
    output logic [NUM_SLOTS*COORD_W-1:0] o_slot_y,
    output logic [7:0]                   o_red,
    output logic [7:0]                   o_green,
    output logic [7:0]                   o_blue,
    output logic                         o_sprite_hit,
    output logic                         o_spawn_drop
);

    localparam int CNT_W = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPAWN_INTERVAL - 1);
    localparam coord_t START_X_C = COORD_W'(START_X);
    localparam coord_t START_Y_C = COORD_W'(START_Y);
    localparam coord_t MAX_X_C   = COORD_W'(MAX_X);
    localparam coord_t MAX_Y_C   = COORD_W'(MAX_Y);
    localparam coord_t STEP_C    = COORD_W'(STEP);

    state_t               state_q, state_d;
    logic                 v_sync_q;
    logic                 tick, run_tick, spawn_due, spawn_found;
    logic [NUM_SLOTS-1:0] spawn_sel;
    logic [CNT_W-1:0]     spawn_cnt_q;
    logic [NUM_SLOTS-1:0] slot_active_q;
    coord_t               slot_x_q [NUM_SLOTS];
    coord_t               slot_y_q [NUM_SLOTS];
    logic                 spawn_drop_q;
    rgb_t                 pix_rgb;

    assign tick      = i_v_sync & ~v_sync_q;
    assign run_tick  = (state_q == RUN) && i_active && !i_state_check && tick;
    assign spawn_due = run_tick && (spawn_cnt_q == CNT_LAST);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            v_sync_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            v_sync_q <= i_v_sync;
        end
    end

    // Losing i_active always wins over pause/unpause.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_active) state_d = RUN;
            RUN:     if (!i_active) state_d = IDLE;
                     else if (i_state_check) state_d = PAUSE;
            PAUSE:   if (!i_active) state_d = IDLE;
                     else if (!i_state_check) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // Free slot is judged on pre-tick occupancy, so a slot retiring this tick is never picked.
    always_comb begin
        spawn_sel   = '0;
        spawn_found = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!slot_active_q[i] && !spawn_found) begin
                spawn_sel[i] = 1'b1;
                spawn_found  = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            slot_active_q <= '0;
            spawn_cnt_q   <= '0;
            spawn_drop_q  <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_x_q[i] <= START_X_C;
                slot_y_q[i] <= START_Y_C;
            end
        end else begin
            spawn_drop_q <= spawn_due && !spawn_found;
            if (state_q == IDLE) begin
                slot_active_q <= '0;
                spawn_cnt_q   <= i_active ? CNT_LAST : '0;
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    slot_x_q[i] <= START_X_C;
                    slot_y_q[i] <= START_Y_C;
                end
            end else if (run_tick) begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (slot_active_q[i]) begin
                        if (slot_x_q[i] >= MAX_X_C || slot_y_q[i] >= MAX_Y_C) begin
                            slot_active_q[i] <= 1'b0;
                            slot_x_q[i]      <= START_X_C;
                            slot_y_q[i]      <= START_Y_C;
                        end else begin
                            slot_x_q[i] <= slot_x_q[i] + STEP_C;
                            slot_y_q[i] <= slot_y_q[i] + STEP_C;
                        end
                    end else if (spawn_due && spawn_sel[i]) begin
                        slot_active_q[i] <= 1'b1;
                        slot_x_q[i]      <= START_X_C;
                        slot_y_q[i]      <= START_Y_C;
                    end
                end
                spawn_cnt_q <= (spawn_cnt_q == CNT_LAST) ? '0 : spawn_cnt_q + CNT_W'(1);
            end
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_pos
        assign o_slot_x[g*COORD_W +: COORD_W] = slot_x_q[g];
        assign o_slot_y[g*COORD_W +: COORD_W] = slot_y_q[g];
    end

    assign o_slot_active = slot_active_q;
    assign o_spawn_drop  = spawn_drop_q;

    terrain_pixel_mux #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_pixel_mux (
        .clk         (i_clk),
        .rst_n       (i_rst_n),
        .slot_hit    (i_slot_hit),
        .slot_active (slot_active_q),
        .slot_rgb    (i_slot_rgb),
        .pix_rgb     (pix_rgb),
        .pix_hit     (o_sprite_hit)
    );

    assign o_red   = pix_rgb.r;
    assign o_green = pix_rgb.g;
    assign o_blue  = pix_rgb.b;

endmodule

// File: tb/tb_terrain_scheduler.sv
// Directed bench for terrain_scheduler: a default-geometry instance plus a narrow-screen
// instance (MAX_X=1007) whose segments leave through the right edge on spawn ticks.
module tb_terrain_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        v_sync = 1'b0;
    logic        active = 1'b0;
    logic        state_check = 1'b0;
    logic [3:0]  slot_hit = 4'b0;
    logic [95:0] slot_rgb = {24'h123456, 24'hC0FFEE, 24'hA0A0A0, 24'h111111};

    logic [3:0]  o_slot_active;
    logic [63:0] o_slot_x, o_slot_y;
    logic [7:0]  o_red, o_green, o_blue;
    logic        o_sprite_hit, o_spawn_drop;

    logic [3:0]  x_slot_active;
    logic [63:0] x_slot_x, x_slot_y;
    logic [7:0]  x_red, x_green, x_blue;
    logic        x_sprite_hit, x_spawn_drop;

    int vectors = 0;
    int miscompares = 0;
    int tick_num = 0;
    int drops = 0;
    int x_drops = 0;
    logic drop_mid, x_drop_mid;

    always #5 clk = ~clk;

    terrain_scheduler dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_v_sync(v_sync), .i_active(active),
        .i_state_check(state_check), .i_slot_hit(slot_hit), .i_slot_rgb(slot_rgb),
        .o_slot_active(o_slot_active), .o_slot_x(o_slot_x), .o_slot_y(o_slot_y),
        .o_red(o_red), .o_green(o_green), .o_blue(o_blue),
        .o_sprite_hit(o_sprite_hit), .o_spawn_drop(o_spawn_drop)
    );

    terrain_scheduler #(.MAX_X(1007), .MAX_Y(2000)) dut_x (
        .i_clk(clk), .i_rst_n(rst_n), .i_v_sync(v_sync), .i_active(active),
        .i_state_check(state_check), .i_slot_hit(slot_hit), .i_slot_rgb(slot_rgb),
        .o_slot_active(x_slot_active), .o_slot_x(x_slot_x), .o_slot_y(x_slot_y),
        .o_red(x_red), .o_green(x_green), .o_blue(x_blue),
        .o_sprite_hit(x_sprite_hit), .o_spawn_drop(x_spawn_drop)
    );

    task automatic frame_tick();
        @(negedge clk) v_sync = 1'b1;
        @(negedge clk);
        drop_mid   = o_spawn_drop;
        x_drop_mid = x_spawn_drop;
        if (drop_mid) drops++;
        if (x_drop_mid) x_drops++;
        v_sync = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_until(input int target);
        while (tick_num < target) begin
            frame_tick();
            tick_num++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (o_slot_active !== 4'b0) begin miscompares++; $display("[TB] FAIL reset_active got %b want 0000", o_slot_active); end
        vectors++; if (o_slot_x !== {4{16'd880}}) begin miscompares++; $display("[TB] FAIL reset_x got %h want %h", o_slot_x, {4{16'd880}}); end
        vectors++; if (o_slot_y !== {4{16'd360}}) begin miscompares++; $display("[TB] FAIL reset_y got %h want %h", o_slot_y, {4{16'd360}}); end
        vectors++; if ({o_red, o_green, o_blue, o_sprite_hit, o_spawn_drop} !== 26'h0) begin miscompares++; $display("[TB] FAIL reset_pix got %h%h%h hit %b drop %b want all 0", o_red, o_green, o_blue, o_sprite_hit, o_spawn_drop); end
        rst_n = 1'b1;
    endtask

    task automatic test_first_spawn();
        active = 1'b1;
        @(negedge clk);
        run_until(1);
        vectors++; if (o_slot_active !== 4'b0001) begin miscompares++; $display("[TB] FAIL first_spawn_active got %b want 0001", o_slot_active); end
        vectors++; if (o_slot_x[15:0] !== 16'd880 || o_slot_y[15:0] !== 16'd360) begin miscompares++; $display("[TB] FAIL first_spawn_pos got %0d,%0d want 880,360", o_slot_x[15:0], o_slot_y[15:0]); end
        run_until(6);
        vectors++; if (o_slot_x[15:0] !== 16'd885 || o_slot_y[15:0] !== 16'd365) begin miscompares++; $display("[TB] FAIL advance5 got %0d,%0d want 885,365", o_slot_x[15:0], o_slot_y[15:0]); end
    endtask

    task automatic test_cadence();
        run_until(33);
        vectors++; if (o_slot_active !== 4'b0011 || o_slot_x[15:0] !== 16'd912 || o_slot_x[31:16] !== 16'd880) begin miscompares++; $display("[TB] FAIL tick33 got act %b x0 %0d x1 %0d want 0011 912 880", o_slot_active, o_slot_x[15:0], o_slot_x[31:16]); end
        run_until(65);
        vectors++; if (o_slot_active !== 4'b0111) begin miscompares++; $display("[TB] FAIL tick65_active got %b want 0111", o_slot_active); end
        run_until(97);
        vectors++; if (o_slot_active !== 4'b1111 || o_slot_x[15:0] !== 16'd976 || o_slot_y[15:0] !== 16'd456) begin miscompares++; $display("[TB] FAIL tick97 got act %b pos %0d,%0d want 1111 976,456", o_slot_active, o_slot_x[15:0], o_slot_y[15:0]); end
        vectors++; if (drops !== 0) begin miscompares++; $display("[TB] FAIL early_drops got %0d want 0", drops); end
    endtask

    task automatic test_drop_and_edge_retire();
        run_until(129);
        vectors++; if (drop_mid !== 1'b1) begin miscompares++; $display("[TB] FAIL drop129 got %b want 1", drop_mid); end
        vectors++; if (o_spawn_drop !== 1'b0) begin miscompares++; $display("[TB] FAIL drop129_pulse got %b want 0", o_spawn_drop); end
        vectors++; if (o_slot_active !== 4'b1111 || o_slot_x[15:0] !== 16'd1008 || o_slot_x[63:48] !== 16'd912) begin miscompares++; $display("[TB] FAIL tick129_slots got act %b x0 %0d x3 %0d want 1111 1008 912", o_slot_active, o_slot_x[15:0], o_slot_x[63:48]); end
        vectors++; if (x_drop_mid !== 1'b1 || x_slot_active !== 4'b1110) begin miscompares++; $display("[TB] FAIL x_tick129 got drop %b act %b want 1 1110", x_drop_mid, x_slot_active); end
        vectors++; if (x_slot_x[15:0] !== 16'd880 || x_slot_y[15:0] !== 16'd360) begin miscompares++; $display("[TB] FAIL x_retire_pos got %0d,%0d want 880,360", x_slot_x[15:0], x_slot_y[15:0]); end
        run_until(161);
        vectors++; if (drop_mid !== 1'b1 || o_slot_x[15:0] !== 16'd1040 || o_slot_y[15:0] !== 16'd520) begin miscompares++; $display("[TB] FAIL tick161 got drop %b pos %0d,%0d want 1 1040,520", drop_mid, o_slot_x[15:0], o_slot_y[15:0]); end
        vectors++; if (x_slot_active !== 4'b1101 || x_slot_x[15:0] !== 16'd880 || x_slot_x[31:16] !== 16'd880) begin miscompares++; $display("[TB] FAIL x_tick161 got act %b x0 %0d x1 %0d want 1101 880 880", x_slot_active, x_slot_x[15:0], x_slot_x[31:16]); end
        vectors++; if (drops !== 2 || x_drops !== 1) begin miscompares++; $display("[TB] FAIL drop_count got %0d/%0d want 2/1", drops, x_drops); end
    endtask

    task automatic test_pause();
        state_check = 1'b1;
        @(negedge clk);
        repeat (10) frame_tick();
        vectors++; if (o_slot_x[15:0] !== 16'd1040 || o_slot_y[15:0] !== 16'd520 || o_slot_active !== 4'b1111) begin miscompares++; $display("[TB] FAIL pause_frozen got act %b pos %0d,%0d want 1111 1040,520", o_slot_active, o_slot_x[15:0], o_slot_y[15:0]); end
        vectors++; if (drops !== 2) begin miscompares++; $display("[TB] FAIL pause_drops got %0d want 2", drops); end
        state_check = 1'b0;
        @(negedge clk);
        run_until(162);
        vectors++; if (o_slot_x[15:0] !== 16'd1041 || o_slot_y[15:0] !== 16'd521) begin miscompares++; $display("[TB] FAIL unpause_step got %0d,%0d want 1041,521", o_slot_x[15:0], o_slot_y[15:0]); end
    endtask

    task automatic test_pixel_mux();
        @(negedge clk) slot_hit = 4'b0110;
        @(negedge clk);
        vectors++; if ({o_sprite_hit, o_red, o_green, o_blue} !== {1'b1, 24'hA0A0A0}) begin miscompares++; $display("[TB] FAIL pix_0110 got %b %h%h%h want 1 a0a0a0", o_sprite_hit, o_red, o_green, o_blue); end
        vectors++; if ({x_sprite_hit, x_red, x_green, x_blue} !== {1'b1, 24'hC0FFEE}) begin miscompares++; $display("[TB] FAIL x_pix_0110 got %b %h%h%h want 1 c0ffee", x_sprite_hit, x_red, x_green, x_blue); end
        slot_hit = 4'b0010;
        @(negedge clk);
        vectors++; if ({x_sprite_hit, x_red, x_green, x_blue} !== 25'h0) begin miscompares++; $display("[TB] FAIL pix_inactive got %b %h%h%h want 0 000000", x_sprite_hit, x_red, x_green, x_blue); end
        slot_hit = 4'b1000;
        @(negedge clk);
        vectors++; if ({o_sprite_hit, o_red, o_green, o_blue} !== {1'b1, 24'h123456}) begin miscompares++; $display("[TB] FAIL pix_1000 got %b %h%h%h want 1 123456", o_sprite_hit, o_red, o_green, o_blue); end
        slot_hit = 4'b0000;
        @(negedge clk);
        vectors++; if ({o_sprite_hit, o_red, o_green, o_blue} !== 25'h0) begin miscompares++; $display("[TB] FAIL pix_none got %b %h%h%h want 0 000000", o_sprite_hit, o_red, o_green, o_blue); end
    endtask

    task automatic test_counter_and_y_retire();
        run_until(193);
        vectors++; if (drop_mid !== 1'b1) begin miscompares++; $display("[TB] FAIL drop193 got %b want 1", drop_mid); end
        vectors++; if (x_slot_active !== 4'b1011) begin miscompares++; $display("[TB] FAIL x_tick193 got %b want 1011", x_slot_active); end
        run_until(361);
        vectors++; if (o_slot_active !== 4'b1111 || o_slot_y[15:0] !== 16'd720) begin miscompares++; $display("[TB] FAIL tick361 got act %b y0 %0d want 1111 720", o_slot_active, o_slot_y[15:0]); end
        run_until(362);
        vectors++; if (o_slot_active !== 4'b1110 || o_slot_x[15:0] !== 16'd880 || o_slot_y[15:0] !== 16'd360) begin miscompares++; $display("[TB] FAIL y_retire got act %b pos %0d,%0d want 1110 880,360", o_slot_active, o_slot_x[15:0], o_slot_y[15:0]); end
        vectors++; if (o_slot_x[31:16] !== 16'd1209) begin miscompares++; $display("[TB] FAIL x1_tick362 got %0d want 1209", o_slot_x[31:16]); end
    endtask

    task automatic test_idle_from_pause();
        state_check = 1'b1;
        @(negedge clk);
        active = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (o_slot_active !== 4'b0 || x_slot_active !== 4'b0) begin miscompares++; $display("[TB] FAIL idle_active got %b/%b want 0000/0000", o_slot_active, x_slot_active); end
        vectors++; if (o_slot_x !== {4{16'd880}} || o_slot_y !== {4{16'd360}}) begin miscompares++; $display("[TB] FAIL idle_pos got %h/%h want all 880/360", o_slot_x, o_slot_y); end
        state_check = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        active = 1'b1;
        @(negedge clk);
        tick_num = 0;
        run_until(1);
        slot_hit = 4'b0001;
        @(negedge clk);
        vectors++; if (o_slot_active !== 4'b0001 || {o_sprite_hit, o_red, o_green, o_blue} !== {1'b1, 24'h111111}) begin miscompares++; $display("[TB] FAIL rerun_spawn got act %b pix %b %h%h%h want 0001 1 111111", o_slot_active, o_sprite_hit, o_red, o_green, o_blue); end
        run_until(3);
        rst_n = 1'b0;
        @(negedge clk);
        vectors++; if (o_slot_active !== 4'b0 || o_slot_x !== {4{16'd880}} || o_slot_y !== {4{16'd360}}) begin miscompares++; $display("[TB] FAIL midrun_reset_slots got act %b x %h y %h want 0 / all 880 / all 360", o_slot_active, o_slot_x, o_slot_y); end
        vectors++; if ({o_sprite_hit, o_red, o_green, o_blue, o_spawn_drop} !== 26'h0) begin miscompares++; $display("[TB] FAIL midrun_reset_pix got %b %h%h%h drop %b want 0", o_sprite_hit, o_red, o_green, o_blue, o_spawn_drop); end
        slot_hit = 4'b0;
        active = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_first_spawn();
        test_cadence();
        test_drop_and_edge_retire();
        test_pause();
        test_pixel_mux();
        test_counter_and_y_retire();
        test_idle_from_pause();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
